coin_acceptor: RTL and testbench

//  Front end for the vending machine coin inputs. Takes the raw, bouncy, asynchronous five/ten

---
 rtl/coin_acceptor.sv | 155 +++++++++++++++
 tb/tb_coin_acceptor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coin_acceptor                                                |
// | Description : Coin switch front end. Synchronises and debounces the raw    |
// |               five/ten coin switches, emits one clean single-cycle pulse   |
// |               per accepted coin and keeps a saturating credit total.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLDOFF_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_five,
   input  logic       btn_ten,
   input  logic       clear_total,
   output logic       five,
   output logic       ten,
   output logic       busy,
   output logic [7:0] total
);

   // Terminal counts. The release counter is compared one early because the
   // transition edge itself is the last quiet sample.
   localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES);
   localparam logic [15:0] QUIET_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      DEBOUNCE     = 3'd1,
      FIRE         = 3'd2,
      WAIT_RELEASE = 3'd3,
      HOLDOFF      = 3'd4
   } state_t;

   state_t      state;
   logic        meta5;
   logic        meta10;
   logic        s5;
   logic        s10;
   logic [15:0] cnt;
   logic        coin_sel;    // 0 = five, 1 = ten
   logic        sel_in;
   logic        other_in;
   logic [8:0]  sum;

   // Two-flop synchronisers for the asynchronous coin switches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta5  <= 1'b0;
         meta10 <= 1'b0;
         s5     <= 1'b0;
         s10    <= 1'b0;
      end else begin
         meta5  <= btn_five;
         meta10 <= btn_ten;
         s5     <= meta5;
         s10    <= meta10;
      end
   end

   // The coin being debounced and the competing coin, seen through coin_sel.
   assign sel_in   = coin_sel ? s10 : s5;
   assign other_in = coin_sel ? s5  : s10;

   // Nine-bit sum so an overflow past 255 is visible and can be clamped.
   assign sum = {1'b0, total} + (coin_sel ? 9'd10 : 9'd5);

   assign busy = (state != IDLE);

   // Coin qualification FSM with registered pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         coin_sel <= 1'b0;
         five     <= 1'b0;
         ten      <= 1'b0;
      end else begin
         five <= 1'b0;
         ten  <= 1'b0;
         case (state)
            IDLE: begin
               if (s5 ^ s10) begin
                  coin_sel <= s10;
                  cnt      <= 16'd1;
                  state    <= DEBOUNCE;
               end else if (s5 & s10) begin
                  cnt   <= '0;
                  state <= WAIT_RELEASE;
               end
            end
            DEBOUNCE: begin
               if (other_in) begin
                  // Two coins at once: reject and wait for both to clear.
                  cnt   <= '0;
                  state <= WAIT_RELEASE;
               end else if (!sel_in) begin
                  // Too short to be a coin: treat as a glitch.
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt >= DEB_LAST) begin
                  cnt   <= '0;
                  five  <= ~coin_sel;
                  ten   <= coin_sel;
                  state <= FIRE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            FIRE: begin
               cnt   <= '0;
               state <= WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
               if (s5 | s10) begin
                  cnt <= '0;
               end else if (cnt >= QUIET_LAST) begin
                  cnt   <= '0;
                  state <= HOLDOFF;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            HOLDOFF: begin
               if (cnt >= HOLD_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Credit accumulator: adds the accepted coin during FIRE, clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total <= '0;
      end else if (clear_total) begin
         total <= '0;
      end else if (state == FIRE) begin
         total <= sum[8] ? 8'hFF : sum[7:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_coin_acceptor                                             |
// | Description : Directed self-checking bench for coin_acceptor with a       |
// |               behavioural reference model compared every cycle.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_coin_acceptor;

   localparam int DEB  = 4;
   localparam int HOLD = 2;

   logic       clk;
   logic       rst_n;
   logic       btn_five;
   logic       btn_ten;
   logic       clear_total;
   logic       five;
   logic       ten;
   logic       busy;
   logic [7:0] total;

   int n_checks = 0;
   int n_pass   = 0;
   int n5_seen  = 0;
   int n10_seen = 0;

   coin_acceptor #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLDOFF_CYCLES  (HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_five    (btn_five),
      .btn_ten     (btn_ten),
      .clear_total (clear_total),
      .five        (five),
      .ten         (ten),
      .busy        (busy),
      .total       (total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Phases of a coin's life: waiting, qualifying, announcing, waiting for
   // the switches to go quiet, and dead time.
   localparam int PH_WAIT  = 0;
   localparam int PH_QUAL  = 1;
   localparam int PH_PULSE = 2;
   localparam int PH_QUIET = 3;
   localparam int PH_DEAD  = 4;

   int   ph;
   int   coin_value;   // 5 or 10
   int   age;          // qualifying samples seen so far
   int   quiet;        // consecutive all-released samples
   int   dead;         // dead cycles elapsed
   int   credit;
   bit   pipe5 [2];    // synchroniser delay line, [1] is what the logic sees
   bit   pipe10 [2];
   bit   m_five;
   bit   m_ten;

   always @(posedge clk or negedge rst_n) begin
      bit a;
      bit b;
      bit mine;
      bit other;
      if (!rst_n) begin
         ph = PH_WAIT; coin_value = 5; age = 0; quiet = 0; dead = 0; credit = 0;
         pipe5[0] = 0; pipe5[1] = 0; pipe10[0] = 0; pipe10[1] = 0;
         m_five = 0; m_ten = 0;
      end else begin
         a = pipe5[1];
         b = pipe10[1];
         m_five = 0;
         m_ten  = 0;
         if (clear_total) credit = 0;
         else if (ph == PH_PULSE) credit = (credit + coin_value > 255) ? 255 : credit + coin_value;
         case (ph)
            PH_WAIT: begin
               if (a != b) begin coin_value = a ? 5 : 10; age = 1; ph = PH_QUAL; end
               else if (a && b) begin quiet = 0; ph = PH_QUIET; end
            end
            PH_QUAL: begin
               mine  = (coin_value == 5) ? a : b;
               other = (coin_value == 5) ? b : a;
               if (other) begin quiet = 0; ph = PH_QUIET; end
               else if (!mine) ph = PH_WAIT;
               else if (age == DEB) begin
                  ph = PH_PULSE;
                  m_five = (coin_value == 5);
                  m_ten  = (coin_value == 10);
               end else age = age + 1;
            end
            PH_PULSE: begin quiet = 0; ph = PH_QUIET; end
            PH_QUIET: begin
               if (a || b) quiet = 0;
               else if (quiet + 1 == DEB) begin dead = 0; ph = PH_DEAD; end
               else quiet = quiet + 1;
            end
            default: begin
               if (dead + 1 == HOLD) ph = PH_WAIT;
               else dead = dead + 1;
            end
         endcase
         pipe5[1]  = pipe5[0];  pipe5[0]  = btn_five;
         pipe10[1] = pipe10[0]; pipe10[0] = btn_ten;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (five === m_five && ten === m_ten && busy === (ph != PH_WAIT) && int'(total) == credit)
            n_pass++;
         else
            $display("FAIL model_cmp @%0t: got five=%b ten=%b busy=%b total=%0d, required five=%b ten=%b busy=%b total=%0d",
                     $time, five, ten, busy, total, m_five, m_ten, (ph != PH_WAIT), credit);
         if (five) n5_seen++;
         if (ten)  n10_seen++;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic coin(input bit is_ten, input int hold, input int rest);
      if (is_ten) btn_ten = 1'b1; else btn_five = 1'b1;
      tick(hold);
      btn_five = 1'b0;
      btn_ten  = 1'b0;
      tick(rest);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int b5;
      int b10;
      bit pat [5];
      rst_n = 1'b1; btn_five = 1'b0; btn_ten = 1'b0; clear_total = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_outputs", {five, ten, busy}, 0);
      check("reset_total", total, 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      tick(2);

      // Clean five press: latency, single pulse, busy drop timing.
      b5 = n5_seen;
      btn_five = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk) check("latency_early", five, 0);
      @(posedge clk);
      @(negedge clk) check("latency_hit", five, 1);
      tick(13);
      btn_five = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk) check("busy_before_drop", busy, 1);
      @(posedge clk);
      @(negedge clk) check("busy_after_drop", busy, 0);
      tick(3);
      check("clean_five_pulses", n5_seen - b5, 1);
      check("clean_five_total", total, 5);

      // Async reset in the middle of a debounce.
      b10 = n10_seen;
      btn_ten = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0; btn_ten = 1'b0;
      #1;
      check("midreset_outputs", {five, ten, busy}, 0);
      check("midreset_total", total, 0);
      #2 rst_n = 1'b1;
      tick(15);
      check("midreset_no_pulse", n10_seen - b10, 0);

      // Bouncing ten press followed by a steady hold.
      b10 = n10_seen;
      pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0;
      for (int i = 0; i < 5; i++) begin btn_ten = pat[i]; tick(1); end
      coin(1'b1, 12, 14);
      check("bounce_pulses", n10_seen - b10, 1);
      check("bounce_total", total, 10);

      // Glitch shorter than the debounce window.
      b5 = n5_seen;
      coin(1'b0, 3, 12);
      check("glitch_pulses", n5_seen - b5, 0);
      check("glitch_total", total, 10);
      check("glitch_idle", busy, 0);

      // Conflicts: simultaneous press, then ten arriving during five's debounce.
      b5 = n5_seen; b10 = n10_seen;
      btn_five = 1'b1; btn_ten = 1'b1;
      coin(1'b0, 10, 14);
      btn_five = 1'b1;
      tick(2);
      coin(1'b1, 10, 14);
      check("conflict_pulses", (n5_seen - b5) + (n10_seen - b10), 0);
      coin(1'b0, 10, 14);
      check("after_conflict_pulse", n5_seen - b5, 1);
      check("after_conflict_total", total, 15);

      // Clear in idle, then saturation.
      clear_total = 1'b1; tick(1); clear_total = 1'b0;
      check("idle_clear", total, 0);
      for (int i = 0; i < 27; i++) begin
         coin(1'b1, 10, 14);
         if (i == 24) check("total_after_25", total, 250);
         if (i == 25) check("total_after_26", total, 255);
      end
      check("total_held_255", total, 255);

      // Clear coinciding with the FIRE cycle.
      b10 = n10_seen;
      btn_ten = 1'b1;
      repeat (7) @(posedge clk);
      #1 clear_total = 1'b1;
      @(negedge clk) check("fire_clear_pulse", ten, 1);
      @(posedge clk); #1 clear_total = 1'b0;
      @(negedge clk) check("fire_clear_total", total, 0);
      tick(4);
      btn_ten = 1'b0;
      tick(14);
      check("fire_clear_one_pulse", n10_seen - b10, 1);
      coin(1'b1, 10, 14);
      check("post_clear_total", total, 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
